// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//   Two-read / one-write general-purpose register file for the 32-bit
//   MIPS-style datapath. 2**ADDR_W registers of DATA_W bits; register 0 is
//   hardwired to zero. Reads are combinational (decode stage), the single
//   write (writeback stage) lands on the rising clock edge.
//
// Ports:
//   clk    in   1       system clock, writes on rising edge
//   rst_n  in   1       asynchronous active-low reset, clears all registers
//   rs     in   ADDR_W  read address, port A
//   rt     in   ADDR_W  read address, port B
//   rw     in   ADDR_W  write address
//   dw     in   DATA_W  write data
//   rwe    in   1       write enable, active-high
//   crs    out  DATA_W  contents of register rs
//   crt    out  DATA_W  contents of register rt
// ----------------------------------------------------------------------------
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] dw,
    input  logic              rwe,
    output logic [DATA_W-1:0] crs,
    output logic [DATA_W-1:0] crt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  wr_sel;

    // One-hot write decode. Bit 0 is forced low so a write to r0 is
    // accepted on the port but never reaches storage.
    always_comb begin
        wr_sel = '0;
        if (rwe) begin
            wr_sel[rw] = 1'b1;
        end
        wr_sel[0] = 1'b0;
    end

    // r0 is part of the array only to keep the read mux regular; it is
    // cleared by reset and never enabled, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= dw;
                end
            end
        end
    end

    // Two independent read muxes. No write bypass: a same-cycle write is
    // visible only after the edge, forwarding belongs to the pipeline.
    // Outputs are also gated by rst_n so reads show zero for the whole
    // reset window, independent of the register clear.
    always_comb begin
        crs = '0;
        crt = '0;
        if (rst_n) begin
            crs = (rs == '0) ? '0 : regs_q[rs];
            crt = (rt == '0) ? '0 : regs_q[rt];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
//   Scoreboard bench for register_file. Stimulus drives inputs just after the
//   rising edge and pushes the expected read pair into a queue; a monitor on
//   the falling edge pops one entry and compares it against crs/crt.
//   Expected values come from a plain array model updated by the write rule.
// ----------------------------------------------------------------------------
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rs, rt, rw;
    logic [DATA_W-1:0] dw;
    logic              rwe;
    logic [DATA_W-1:0] crs, crt;

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rs   (rs),
        .rt   (rt),
        .rw   (rw),
        .dw   (dw),
        .rwe  (rwe),
        .crs  (crs),
        .crt  (crt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] ers;
        logic [DATA_W-1:0] ert;
        int                ars;
        int                art;
    } exp_t;

    exp_t    exp_q[$];
    string   name_q[$];
    int      vectors = 0;
    int      miscompares = 0;
    logic [DATA_W-1:0] model [DEPTH];

    // Reference read: zero during reset or for r0, else stored word.
    function automatic logic [DATA_W-1:0] ref_read(input int a);
        if (!rst_n || a == 0) return '0;
        return model[a];
    endfunction

    // One clock: the model applies the write rule at the edge, then inputs
    // may change 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        if (rst_n && rwe && rw != 0) model[rw] = dw;
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Drive read addresses and queue the expected pair for the monitor.
    task automatic probe(input string nm, input int a, input int b);
        exp_t e;
        rs = a[ADDR_W-1:0];
        rt = b[ADDR_W-1:0];
        e.ers = ref_read(a);
        e.ert = ref_read(b);
        e.ars = a;
        e.art = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic set_write(input bit en, input int a, input logic [DATA_W-1:0] d);
        rwe = en;
        rw  = a[ADDR_W-1:0];
        dw  = d;
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            vectors++;
            if (crs !== e.ers || crt !== e.ert) begin
                miscompares++;
                $display("FAIL %s: rs=%0d crs=%h (required %h), rt=%0d crt=%h (required %h)",
                         nm, e.ars, crs, e.ers, e.art, crt, e.ert);
            end
        end
    end

    initial begin
        int wait_cyc;
        logic [DATA_W-1:0] rd;
        rs = '0; rt = '0; rw = '0; dw = '0; rwe = 1'b0;
        assert_reset();
        cyc();

        // Reset state, including a write attempt while in reset
        set_write(1'b1, 9, 32'hCAFE_F00D);
        probe("in_reset", 9, 31);
        cyc();
        set_write(1'b0, 0, '0);
        rst_n = 1'b1;
        probe("after_release", 9, 1);
        cyc();

        // Mid-run asynchronous reset: r5 visible, then cleared with no edge
        set_write(1'b1, 5, 32'hDEAD_BEEF);
        cyc();
        set_write(1'b0, 0, '0);
        probe("r5_written", 5, 5);
        cyc();
        assert_reset();
        probe("async_reset_r5", 5, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i += 2) begin
            probe("all_zero_after_reset", i, i + 1);
            cyc();
        end

        // Write/read r7
        set_write(1'b1, 7, 32'h0000_A52A);
        cyc();
        set_write(1'b0, 0, '0);
        probe("write_r7", 6, 7);
        cyc();

        // Zero register write is discarded
        set_write(1'b1, 0, 32'h0000_A52A);
        cyc();
        set_write(1'b0, 0, '0);
        probe("r0_discard", 0, 0);
        cyc();

        // Write disabled
        set_write(1'b0, 1, 32'hFFFF_FFFF);
        cyc();
        probe("rwe_low", 1, 1);
        cyc();

        // Read-during-write: old value before the edge, new one after
        set_write(1'b1, 3, 32'h1111_1111);
        cyc();
        set_write(1'b1, 3, 32'h2222_2222);
        probe("rdw_before_edge", 3, 3);
        cyc();
        set_write(1'b0, 0, '0);
        probe("rdw_after_edge", 3, 3);
        cyc();

        // Sweep: r_i = i*0x01010101, read i and 31-i together
        for (int i = 1; i < DEPTH; i++) begin
            rd = 32'h0101_0101 * i;
            set_write(1'b1, i, rd);
            cyc();
        end
        set_write(1'b0, 0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            probe("sweep_dual", i, DEPTH - 1 - i);
            cyc();
        end

        // Randomized traffic with reads concurrent to writes
        for (int n = 0; n < 400; n++) begin
            set_write(($urandom_range(0, 3) != 0), $urandom_range(0, DEPTH - 1), $urandom);
            probe("random", $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            cyc();
        end
        set_write(1'b0, 0, '0);

        // Drain the scoreboard with a bound
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            cyc();
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
